// File: rtl/mmio_pkg.sv
// IO page register offsets and bit positions
// shared by the miniRV peripheral hub.
package mmio_pkg;

  localparam logic [11:0] OFF_SEG  = 12'h000;
  localparam logic [11:0] OFF_TCNT = 12'h020;
  localparam logic [11:0] OFF_TDIV = 12'h024;
  localparam logic [11:0] OFF_TCMP = 12'h028;
  localparam logic [11:0] OFF_STAT = 12'h02C;
  localparam logic [11:0] OFF_CTRL = 12'h030;
  localparam logic [11:0] OFF_LED  = 12'h060;
  localparam logic [11:0] OFF_SW   = 12'h070;

  localparam int STAT_TMATCH = 0;
  localparam int STAT_SWCHG  = 1;

  localparam int CTRL_TEN = 0;
  localparam int CTRL_TIE = 1;
  localparam int CTRL_SIE = 2;

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser + shared-counter debouncer.
// Ports: clk_i, rst_n_i, sw_i (raw), stable_o, changed_o (1-cycle pulse).
module sw_debounce
  import mmio_pkg::*;
#(
  parameter int W          = 24,
  parameter int DEB_CYCLES = 20000
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] stable_o,
  output logic         changed_o
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  r_meta;
  logic [W-1:0]  r_sync;
  logic [W-1:0]  r_stable;
  logic [CW-1:0] r_cnt;

  logic w_diff;
  logic w_done;

  assign w_diff = (r_sync != r_stable);
  assign w_done = w_diff && (r_cnt == LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_meta <= sw_i;
      r_sync <= r_meta;
      // any return to the stable value restarts the window
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt    <= '0;
        r_stable <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable_o  = r_stable;
  // combinational so SWCHG lands on the same edge as SW
  assign changed_o = w_done;

endmodule

// File: rtl/mmio_periph.sv
// miniRV IO page hub: SEG, LED, debounced SW, prescaled timer, IRQ.
// Ports: clk_i, rst_n_i, addr_i/we_i/wr_data_i/rd_data_o bus, sw_data_i, seg_data_o, led_o, irq_o.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter int SW_W       = 24,
  parameter int LED_W      = 24,
  parameter int DEB_CYCLES = 20000,
  parameter int TIMER_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [11:0]       addr_i,
  input  logic              we_i,
  input  logic [31:0]       wr_data_i,
  input  logic [SW_W-1:0]   sw_data_i,
  output logic [31:0]       rd_data_o,
  output logic [31:0]       seg_data_o,
  output logic [LED_W-1:0]  led_o,
  output logic              irq_o
);

  logic [31:0]        r_seg;
  logic [LED_W-1:0]   r_led;
  logic [TIMER_W-1:0] r_tcnt;
  logic [TIMER_W-1:0] r_pre;
  logic [TIMER_W-1:0] r_tdiv;
  logic [TIMER_W-1:0] r_tcmp;
  logic [2:0]         r_ctrl;
  logic [1:0]         r_stat;
  logic               r_irq;

  logic [11:0]        w_addr;
  logic               w_unused_addr;
  logic [SW_W-1:0]    w_sw;
  logic               w_sw_chg;
  logic [TIMER_W-1:0] w_wdt;
  logic [TIMER_W-1:0] w_tcnt_nxt;
  logic               w_tick;
  logic               w_match;
  logic [1:0]         w_clr;
  logic [1:0]         w_set;
  logic               w_wr_seg;
  logic               w_wr_tcnt;
  logic               w_wr_tdiv;
  logic               w_wr_tcmp;
  logic               w_wr_stat;
  logic               w_wr_ctrl;
  logic               w_wr_led;

  assign w_addr        = {addr_i[11:2], 2'b00};
  assign w_unused_addr = ^addr_i[1:0];

  assign w_wr_seg  = we_i && (w_addr == OFF_SEG);
  assign w_wr_tcnt = we_i && (w_addr == OFF_TCNT);
  assign w_wr_tdiv = we_i && (w_addr == OFF_TDIV);
  assign w_wr_tcmp = we_i && (w_addr == OFF_TCMP);
  assign w_wr_stat = we_i && (w_addr == OFF_STAT);
  assign w_wr_ctrl = we_i && (w_addr == OFF_CTRL);
  assign w_wr_led  = we_i && (w_addr == OFF_LED);

  sw_debounce #(
    .W          (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .sw_i      (sw_data_i),
    .stable_o  (w_sw),
    .changed_o (w_sw_chg)
  );

  assign w_wdt      = wr_data_i[TIMER_W-1:0];
  assign w_tcnt_nxt = r_tcnt + 1'b1;
  assign w_tick     = r_ctrl[CTRL_TEN] && (r_pre == r_tdiv);
  // a CPU load of TCNT suppresses compare on that edge
  assign w_match    = w_tick && !w_wr_tcnt && (w_tcnt_nxt == r_tcmp);

  assign w_clr = w_wr_stat ? wr_data_i[1:0] : 2'b00;
  assign w_set = {w_sw_chg, w_match};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_seg  <= '0;
      r_led  <= '0;
      r_tdiv <= '0;
      r_tcmp <= '1;
      r_ctrl <= '0;
    end else begin
      if (w_wr_seg)  r_seg  <= wr_data_i;
      if (w_wr_led)  r_led  <= wr_data_i[LED_W-1:0];
      if (w_wr_tdiv) r_tdiv <= w_wdt;
      if (w_wr_tcmp) r_tcmp <= w_wdt;
      if (w_wr_ctrl) r_ctrl <= wr_data_i[2:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pre  <= '0;
      r_tcnt <= '0;
    end else begin
      if (w_wr_tdiv || w_tick) begin
        r_pre <= '0;
      end else if (r_ctrl[CTRL_TEN]) begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_wr_tcnt) begin
        r_tcnt <= w_wdt;
      end else if (w_tick) begin
        r_tcnt <= w_tcnt_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat <= '0;
      r_irq  <= 1'b0;
    end else begin
      // set beats a simultaneous W1C
      r_stat <= (r_stat & ~w_clr) | w_set;
      r_irq  <= (r_stat[STAT_TMATCH] & r_ctrl[CTRL_TIE])
              | (r_stat[STAT_SWCHG]  & r_ctrl[CTRL_SIE]);
    end
  end

  always_comb begin
    rd_data_o = '0;
    unique case (1'b1)
      (w_addr == OFF_SEG):  rd_data_o = r_seg;
      (w_addr == OFF_TCNT): rd_data_o = 32'(r_tcnt);
      (w_addr == OFF_TDIV): rd_data_o = 32'(r_tdiv);
      (w_addr == OFF_TCMP): rd_data_o = 32'(r_tcmp);
      (w_addr == OFF_STAT): rd_data_o = 32'(r_stat);
      (w_addr == OFF_CTRL): rd_data_o = 32'(r_ctrl);
      (w_addr == OFF_LED):  rd_data_o = 32'(r_led);
      (w_addr == OFF_SW):   rd_data_o = 32'(w_sw);
      default:              rd_data_o = '0;
    endcase
  end

  assign seg_data_o = r_seg;
  assign led_o      = r_led;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph.
// Randomised bus/switch/timer stimulus against an arithmetic model.
module tb_mmio_periph;

  localparam int SW_W  = 24;
  localparam int LED_W = 24;
  localparam int DEB   = 4;
  localparam int TW    = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [11:0]       addr = '0;
  logic              we = 1'b0;
  logic [31:0]       wdata = '0;
  logic [SW_W-1:0]   sw = '0;
  logic [31:0]       rd_data;
  logic [31:0]       seg;
  logic [LED_W-1:0]  led;
  logic              irq;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sw_model = '0;

  mmio_periph #(
    .SW_W       (SW_W),
    .LED_W      (LED_W),
    .DEB_CYCLES (DEB),
    .TIMER_W    (TW)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .addr_i     (addr),
    .we_i       (we),
    .wr_data_i  (wdata),
    .sw_data_i  (sw),
    .rd_data_o  (rd_data),
    .seg_data_o (seg),
    .led_o      (led),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  // called at a negedge; write lands on the following posedge
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (seg !== 32'h0) begin
      n_err++; $display("FAIL rst_seg got %h want 0", seg);
    end
    n_vec++;
    if (led !== '0) begin
      n_err++; $display("FAIL rst_led got %h want 0", led);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL rst_irq got %b want 0", irq);
    end
    rd(12'h028, v);
    n_vec++;
    if (v !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL rst_tcmp got %h want ffffffff", v);
    end
    rd(12'h0FC, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL rst_unmapped got %h want 0", v);
    end
    rd(12'h02C, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL rst_stat got %h want 0", v);
    end
  endtask

  task automatic test_regs;
    logic [31:0] v;
    logic [31:0] s;
    logic [31:0] l;
    for (int i = 0; i < 6; i++) begin
      s = (i == 0) ? 32'h1234_5678 : $urandom;
      l = (i == 0) ? 32'h00AB_CDEF : $urandom;
      wr(12'h000, s);
      wr(12'h060 | 12'($urandom_range(0, 3)), l);
      n_vec++;
      if (seg !== s) begin
        n_err++; $display("FAIL seg_out got %h want %h", seg, s);
      end
      n_vec++;
      if (led !== l[LED_W-1:0]) begin
        n_err++; $display("FAIL led_out got %h want %h", led, l[LED_W-1:0]);
      end
      rd(12'h000, v);
      n_vec++;
      if (v !== s) begin
        n_err++; $display("FAIL seg_rd got %h want %h", v, s);
      end
      rd(12'h060, v);
      n_vec++;
      if (v !== {8'h00, l[23:0]}) begin
        n_err++; $display("FAIL led_rd got %h want %h", v, {8'h00, l[23:0]});
      end
    end
    wr(12'h070, 32'hFFFF_FFFF);
    wr(12'h0FC, 32'hDEAD_BEEF);
    rd(12'h070, v);
    n_vec++;
    if (v !== sw_model) begin
      n_err++; $display("FAIL sw_ro got %h want %h", v, sw_model);
    end
    rd(12'h0FC, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL unmapped_wr got %h want 0", v);
    end
    rd(12'h000, v);
    n_vec++;
    if (v !== s) begin
      n_err++; $display("FAIL seg_kept got %h want %h", v, s);
    end
  endtask

  task automatic test_debounce;
    logic [31:0] v;
    logic [31:0] nv;
    logic [31:0] g;
    wr(12'h02C, 32'h3);
    wr(12'h030, 32'h4);
    for (int i = 0; i < 4; i++) begin
      nv = (i == 0) ? 32'h00A5A5 : {8'h00, 24'($urandom)};
      if (nv == sw_model) nv = nv ^ 32'h1;
      sw = nv[SW_W-1:0];
      for (int k = 1; k <= 2 + DEB; k++) begin
        @(negedge clk);
        rd(12'h070, v);
        n_vec++;
        if (v !== ((k == 2 + DEB) ? nv : sw_model)) begin
          n_err++;
          $display("FAIL deb_step k=%0d got %h want %h", k, v,
                   (k == 2 + DEB) ? nv : sw_model);
        end
      end
      sw_model = nv;
      rd(12'h02C, v);
      n_vec++;
      if (v[1] !== 1'b1) begin
        n_err++; $display("FAIL swchg_set got %b want 1", v[1]);
      end
      @(negedge clk);
      n_vec++;
      if (irq !== 1'b1) begin
        n_err++; $display("FAIL sie_irq got %b want 1", irq);
      end
      wr(12'h02C, 32'h2);
    end
    wr(12'h030, 32'h0);
    for (int i = 0; i < 3; i++) begin
      g = sw_model ^ {8'h00, 24'($urandom_range(1, 24'hFF_FFFF))};
      sw = g[SW_W-1:0];
      repeat (3) @(negedge clk);
      sw = sw_model[SW_W-1:0];
      repeat (12) @(negedge clk);
      rd(12'h070, v);
      n_vec++;
      if (v !== sw_model) begin
        n_err++; $display("FAIL glitch got %h want %h", v, sw_model);
      end
      rd(12'h02C, v);
      n_vec++;
      if (v[1] !== 1'b0) begin
        n_err++; $display("FAIL glitch_flag got %b want 0", v[1]);
      end
    end
  endtask

  task automatic test_timer_match;
    logic [31:0] v;
    wr(12'h030, 32'h0);
    wr(12'h028, 32'd3);
    wr(12'h024, 32'd2);
    wr(12'h020, 32'd0);
    wr(12'h02C, 32'h3);
    wr(12'h030, 32'h3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rd(12'h02C, v);
      n_vec++;
      if (v[0] !== (k >= 9)) begin
        n_err++; $display("FAIL tmatch k=%0d got %b want %b", k, v[0], k >= 9);
      end
      n_vec++;
      if (irq !== (k >= 10)) begin
        n_err++; $display("FAIL tirq k=%0d got %b want %b", k, irq, k >= 10);
      end
    end
    wr(12'h02C, 32'h1);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL w1c_lag got %b want 1", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL w1c_irq got %b want 0", irq);
    end
    wr(12'h030, 32'h0);
  endtask

  task automatic test_timer_wrap;
    logic [31:0] v;
    logic [31:0] x;
    wr(12'h024, 32'd0);
    wr(12'h020, 32'hFFFF_FFFF);
    wr(12'h030, 32'h1);
    rd(12'h020, v);
    n_vec++;
    if (v !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL wrap_pre got %h want ffffffff", v);
    end
    @(negedge clk);
    rd(12'h020, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL wrap got %h want 0", v);
    end
    x = 32'h8000_0000 | $urandom;
    wr(12'h028, x);
    wr(12'h02C, 32'h1);
    wr(12'h020, x);
    rd(12'h020, v);
    n_vec++;
    if (v !== x) begin
      n_err++; $display("FAIL tcnt_wr_wins got %h want %h", v, x);
    end
    rd(12'h02C, v);
    n_vec++;
    if (v[0] !== 1'b0) begin
      n_err++; $display("FAIL no_match_on_load got %b want 0", v[0]);
    end
    wr(12'h030, 32'h0);
  endtask

  task automatic test_timer_random;
    logic [31:0] v;
    logic [31:0] start;
    logic [31:0] cmp;
    logic [31:0] expc;
    logic        expm;
    int          m;
    int          d;
    int          ticks;
    for (int i = 0; i < 8; i++) begin
      m     = $urandom_range(5, 40);
      d     = $urandom_range(0, 4);
      ticks = (m + 1) / (d + 1);
      start = $urandom;
      cmp   = start + 32'($urandom_range(1, ticks + 3));
      expc  = start + 32'(ticks);
      expm  = 1'b0;
      for (int k = 1; k <= ticks; k++)
        if (start + 32'(k) == cmp) expm = 1'b1;
      wr(12'h024, 32'(d));
      wr(12'h020, start);
      wr(12'h028, cmp);
      wr(12'h02C, 32'h3);
      wr(12'h030, 32'h1);
      repeat (m) @(negedge clk);
      wr(12'h030, 32'h0);
      repeat (3) @(negedge clk);
      rd(12'h020, v);
      n_vec++;
      if (v !== expc) begin
        n_err++; $display("FAIL tcnt_rand d=%0d m=%0d got %h want %h", d, m, v, expc);
      end
      rd(12'h02C, v);
      n_vec++;
      if (v[0] !== expm) begin
        n_err++; $display("FAIL tmatch_rand got %b want %b", v[0], expm);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    wr(12'h000, 32'hCAFE_F00D);
    wr(12'h060, 32'h0012_3456);
    wr(12'h024, 32'd0);
    wr(12'h028, 32'd2);
    wr(12'h020, 32'd0);
    wr(12'h02C, 32'h3);
    wr(12'h030, 32'h3);
    repeat (4) @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL pre_rst_irq got %b want 1", irq);
    end
    sw = sw_model[SW_W-1:0] ^ 24'h5A5A5A;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (seg !== 32'h0) begin
      n_err++; $display("FAIL arst_seg got %h want 0", seg);
    end
    n_vec++;
    if (led !== '0) begin
      n_err++; $display("FAIL arst_led got %h want 0", led);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL arst_irq got %b want 0", irq);
    end
    rd(12'h020, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL arst_tcnt got %h want 0", v);
    end
    rd(12'h070, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL arst_sw got %h want 0", v);
    end
    sw = '0;
    sw_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_debounce();
    test_timer_match();
    test_timer_wrap();
    test_timer_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
